// File: rtl/dpram_param_if.sv
// Bus bundle for dpram_param: write port, read port, read result and clear-engine handshake.
interface dpram_param_if #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 18
);
  logic              wren;
  logic [ADDR_W-1:0] wraddress;
  logic [DATA_W-1:0] data;
  logic              rden;
  logic [ADDR_W-1:0] rdaddress;
  logic [DATA_W-1:0] q;
  logic              q_valid;
  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;
  logic              wr_drop;

  modport master (
    output wren, wraddress, data, rden, rdaddress, clr_start,
    input  q, q_valid, clr_busy, clr_done, wr_drop
  );

  modport slave (
    input  wren, wraddress, data, rden, rdaddress, clr_start,
    output q, q_valid, clr_busy, clr_done, wr_drop
  );
endinterface

// File: rtl/dpram_param.sv
// Simple dual-port RAM (one write, one read port) with a full-memory clear engine.
// Read latency is 1 + OUT_REG cycles after the request edge; RDW_MODE picks old/new data
// on a same-address read-during-write. Memory contents are never touched by reset.
module dpram_param #(
  parameter int              DATA_W    = 14,
  parameter int              ADDR_W    = 18,
  parameter int              DEPTH     = 2**ADDR_W,
  parameter int              OUT_REG   = 1,
  parameter int              RDW_MODE  = 0,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
  input  logic         clock,
  input  logic         aclr_n,
  dpram_param_if.slave bus
);

  localparam int                CNT_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(DEPTH - 1);
  localparam int                STAGES  = (OUT_REG != 0) ? 1 : 0;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                run;
  logic                clr_wr, usr_wr, wr_en, drop_nxt;
  logic                in_range_w, in_range_r;
  logic [CNT_W-1:0]    wr_idx, rd_idx;
  logic [DATA_W-1:0]   wr_dat, rd_word;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [STAGES:0]     vld_pipe;
  logic [DATA_W-1:0]   dat_pipe [STAGES+1];
  logic [DATA_W-1:0]   q_r;
  logic                q_valid_r, wr_drop_r;

  // Reset-release qualifier: requests are taken from the second edge after aclr_n rises.
  always_ff @(posedge clock or negedge aclr_n)
    if (!aclr_n) run <= 1'b0;
    else         run <= 1'b1;

  // Clear FSM state and address counter.
  always_ff @(posedge clock or negedge aclr_n)
    if (!aclr_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end

  // Clear FSM next state; counter stops at DEPTH-1 and clr_start outside IDLE is ignored.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:  if (run && bus.clr_start) begin
               state_nxt = CLEAR;
               cnt_nxt   = '0;
             end
      CLEAR: if (cnt == LAST) state_nxt = DONE;
             else             cnt_nxt   = cnt + 1'b1;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single write port shared by the clear engine (priority) and the user.
  always_comb begin
    in_range_w = ({1'b0, bus.wraddress} < DEPTH_L);
    in_range_r = ({1'b0, bus.rdaddress} < DEPTH_L);
    clr_wr     = (state == CLEAR);
    usr_wr     = run && bus.wren && !clr_wr && in_range_w;
    drop_nxt   = run && bus.wren && (clr_wr || !in_range_w);
    wr_en      = clr_wr || usr_wr;
    wr_idx     = clr_wr ? cnt : bus.wraddress[CNT_W-1:0];
    wr_dat     = clr_wr ? CLR_VALUE : bus.data;
    rd_idx     = bus.rdaddress[CNT_W-1:0];
  end

  // Storage array; deliberately outside the reset domain.
  always_ff @(posedge clock)
    if (wr_en) mem[wr_idx] <= wr_dat;

  // Read word at the request edge: zero when out of range, bypassed write data in new-data mode.
  always_comb begin
    rd_word = '0;
    if (in_range_r) begin
      rd_word = mem[rd_idx];
      if (RDW_MODE != 0 && wr_en && wr_idx == rd_idx) rd_word = wr_dat;
    end
  end

  // Read pipeline and output register; q only moves when a read completes.
  always_ff @(posedge clock or negedge aclr_n)
    if (!aclr_n) begin
      vld_pipe  <= '0;
      dat_pipe  <= '{default: '0};
      q_r       <= '0;
      q_valid_r <= 1'b0;
    end else begin
      vld_pipe[0] <= run && bus.rden;
      if (run && bus.rden) dat_pipe[0] <= rd_word;
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
      q_valid_r <= vld_pipe[STAGES];
      if (vld_pipe[STAGES]) q_r <= dat_pipe[STAGES];
    end

  // Dropped-write pulse, one cycle after the discarded request.
  always_ff @(posedge clock or negedge aclr_n)
    if (!aclr_n) wr_drop_r <= 1'b0;
    else         wr_drop_r <= drop_nxt;

  assign bus.q        = q_r;
  assign bus.q_valid  = q_valid_r;
  assign bus.wr_drop  = wr_drop_r;
  assign bus.clr_busy = (state == CLEAR);
  assign bus.clr_done = (state == DONE);

endmodule

// File: tb/tb_dpram_param.sv
// Directed bench: three dpram_param instances share one stimulus bus.
//   a: DEPTH 16, OUT_REG 1, old-data RDW    b: same, new-data RDW    c: DEPTH 12, OUT_REG 0
module tb_dpram_param;

  logic        clock = 1'b0;
  logic        aclr_n;
  logic        wren, rden, clr_start;
  logic [3:0]  wraddress, rdaddress;
  logic [13:0] data;

  int n_chk = 0;
  int n_err = 0;

  logic [13:0] exp_a [16];
  logic [13:0] exp_c [16];
  int busy_a, busy_b, busy_c, done_a, done_c, done_ja, done_jc;

  always #5 clock = ~clock;

  dpram_param_if #(.DATA_W(14), .ADDR_W(4)) if_a ();
  dpram_param_if #(.DATA_W(14), .ADDR_W(4)) if_b ();
  dpram_param_if #(.DATA_W(14), .ADDR_W(4)) if_c ();

  assign if_a.wren = wren; assign if_a.wraddress = wraddress; assign if_a.data = data;
  assign if_a.rden = rden; assign if_a.rdaddress = rdaddress; assign if_a.clr_start = clr_start;
  assign if_b.wren = wren; assign if_b.wraddress = wraddress; assign if_b.data = data;
  assign if_b.rden = rden; assign if_b.rdaddress = rdaddress; assign if_b.clr_start = clr_start;
  assign if_c.wren = wren; assign if_c.wraddress = wraddress; assign if_c.data = data;
  assign if_c.rden = rden; assign if_c.rdaddress = rdaddress; assign if_c.clr_start = clr_start;

  dpram_param #(.DATA_W(14), .ADDR_W(4), .DEPTH(16), .OUT_REG(1), .RDW_MODE(0),
                .CLR_VALUE(14'h3FFF)) dut_a (.clock(clock), .aclr_n(aclr_n), .bus(if_a.slave));
  dpram_param #(.DATA_W(14), .ADDR_W(4), .DEPTH(16), .OUT_REG(1), .RDW_MODE(1),
                .CLR_VALUE(14'h3FFF)) dut_b (.clock(clock), .aclr_n(aclr_n), .bus(if_b.slave));
  dpram_param #(.DATA_W(14), .ADDR_W(4), .DEPTH(12), .OUT_REG(0), .RDW_MODE(0),
                .CLR_VALUE(14'h3FFF)) dut_c (.clock(clock), .aclr_n(aclr_n), .bus(if_c.slave));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_a_q"}, 32'(if_a.q), 32'h0);        chk({tag, "_a_qv"}, 32'(if_a.q_valid), 32'h0);
    chk({tag, "_a_busy"}, 32'(if_a.clr_busy), 32'h0); chk({tag, "_a_done"}, 32'(if_a.clr_done), 32'h0);
    chk({tag, "_a_drop"}, 32'(if_a.wr_drop), 32'h0);
    chk({tag, "_b_q"}, 32'(if_b.q), 32'h0);        chk({tag, "_b_qv"}, 32'(if_b.q_valid), 32'h0);
    chk({tag, "_c_q"}, 32'(if_c.q), 32'h0);        chk({tag, "_c_qv"}, 32'(if_c.q_valid), 32'h0);
    chk({tag, "_c_busy"}, 32'(if_c.clr_busy), 32'h0); chk({tag, "_c_done"}, 32'(if_c.clr_done), 32'h0);
  endtask

  // Back-to-back reads of addresses 0..n-1; a/b answer two edges later, c one edge later.
  task automatic rd_range(input int n);
    for (int i = 0; i < n + 3; i++) begin
      wren = 1'b0; rden = (i < n); rdaddress = 4'(i);
      @(negedge clock);
      chk($sformatf("rd_a_qv%0d", i), 32'(if_a.q_valid), 32'(i >= 2 && i < n + 2));
      chk($sformatf("rd_c_qv%0d", i), 32'(if_c.q_valid), 32'(i >= 1 && i < n + 1));
      if (i >= 2 && i < n + 2) begin
        chk($sformatf("rd_a_q%0d", i - 2), 32'(if_a.q), 32'(exp_a[i-2]));
        chk($sformatf("rd_b_q%0d", i - 2), 32'(if_b.q), 32'(exp_a[i-2]));
      end
      if (i >= 1 && i < n + 1)
        chk($sformatf("rd_c_q%0d", i - 1), 32'(if_c.q), 32'(exp_c[i-1]));
    end
    rden = 1'b0;
  endtask

  initial begin
    aclr_n = 1'b0; wren = 1'b0; rden = 1'b0; clr_start = 1'b0;
    wraddress = '0; rdaddress = '0; data = '0;
    repeat (2) @(negedge clock);
    chk_idle("rst");

    // Release; a read at the first edge must be ignored, writes start at the second.
    aclr_n = 1'b1; rden = 1'b1; rdaddress = 4'd0;
    @(negedge clock);
    rden = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wren = 1'b1; wraddress = 4'(i); data = 14'(16'h1000 + i);
      exp_a[i] = 14'(16'h1000 + i); exp_c[i] = 14'(16'h1000 + i);
      @(negedge clock);
      chk($sformatf("early_a_qv%0d", i), 32'(if_a.q_valid), 32'h0);
      chk($sformatf("early_c_qv%0d", i), 32'(if_c.q_valid), 32'h0);
    end
    wren = 1'b0;
    rd_range(10);

    // Same-address read-during-write on address 5.
    wren = 1'b1; wraddress = 4'd5; data = 14'h2005; rden = 1'b1; rdaddress = 4'd5;
    @(negedge clock);
    wren = 1'b0;
    @(negedge clock);
    chk("rdw_c_old", 32'(if_c.q), 32'h1005); chk("rdw_c_qv", 32'(if_c.q_valid), 32'h1);
    rden = 1'b0;
    @(negedge clock);
    chk("rdw_a_old", 32'(if_a.q), 32'h1005); chk("rdw_b_new", 32'(if_b.q), 32'h2005);
    chk("rdw_c_next", 32'(if_c.q), 32'h2005);
    @(negedge clock);
    chk("rdw_a_next", 32'(if_a.q), 32'h2005); chk("rdw_b_next", 32'(if_b.q), 32'h2005);
    chk("hold_c_qv", 32'(if_c.q_valid), 32'h0); chk("hold_c_q", 32'(if_c.q), 32'h2005);
    @(negedge clock);
    chk("hold_a_qv", 32'(if_a.q_valid), 32'h0); chk("hold_a_q", 32'(if_a.q), 32'h2005);

    // Address 13: in range for a/b, beyond DEPTH for c.
    wren = 1'b1; wraddress = 4'd13; data = 14'h0D0D;
    @(negedge clock);
    chk("oor_c_drop", 32'(if_c.wr_drop), 32'h1); chk("oor_a_drop", 32'(if_a.wr_drop), 32'h0);
    wren = 1'b0;
    @(negedge clock);
    chk("oor_c_drop_end", 32'(if_c.wr_drop), 32'h0);
    rden = 1'b1; rdaddress = 4'd13;
    @(negedge clock);
    rden = 1'b0;
    @(negedge clock);
    chk("oor_c_q", 32'(if_c.q), 32'h0); chk("oor_c_qv", 32'(if_c.q_valid), 32'h1);
    @(negedge clock);
    chk("oor_a_q", 32'(if_a.q), 32'h0D0D); chk("oor_a_qv", 32'(if_a.q_valid), 32'h1);

    // Full clear with a blocked write and a second clr_start while busy.
    clr_start = 1'b1;
    @(negedge clock);
    clr_start = 1'b0;
    busy_a = 0; busy_b = 0; busy_c = 0; done_a = 0; done_c = 0; done_ja = -1; done_jc = -1;
    for (int j = 0; j < 30; j++) begin
      if (if_a.clr_busy) busy_a++;
      if (if_b.clr_busy) busy_b++;
      if (if_c.clr_busy) busy_c++;
      if (if_a.clr_done) begin done_a++; done_ja = j; end
      if (if_c.clr_done) begin done_c++; done_jc = j; end
      if (j == 3) begin
        chk("clr_a_drop", 32'(if_a.wr_drop), 32'h1);
        chk("clr_c_drop", 32'(if_c.wr_drop), 32'h1);
      end
      wren = (j == 2); wraddress = 4'd3; data = 14'h1234; clr_start = (j == 2);
      @(negedge clock);
    end
    wren = 1'b0; clr_start = 1'b0;
    chk("clr_a_busy_cycles", 32'(busy_a), 32'd16); chk("clr_b_busy_cycles", 32'(busy_b), 32'd16);
    chk("clr_c_busy_cycles", 32'(busy_c), 32'd12);
    chk("clr_a_done_cnt", 32'(done_a), 32'd1);     chk("clr_c_done_cnt", 32'(done_c), 32'd1);
    chk("clr_a_done_at", 32'(done_ja), 32'd16);    chk("clr_c_done_at", 32'(done_jc), 32'd12);
    for (int i = 0; i < 16; i++) begin
      exp_a[i] = 14'h3FFF;
      exp_c[i] = (i < 12) ? 14'h3FFF : 14'h0;
    end
    rd_range(16);

    // Refill, then reset in the middle of a clear.
    for (int i = 0; i < 16; i++) begin
      wren = 1'b1; wraddress = 4'(i); data = 14'(16'h0100 + i);
      @(negedge clock);
    end
    wren = 1'b0;
    clr_start = 1'b1;
    @(negedge clock);
    clr_start = 1'b0;
    repeat (6) @(negedge clock);
    chk("int_a_busy_pre", 32'(if_a.clr_busy), 32'h1);
    aclr_n = 1'b0;
    #1;
    chk_idle("int");
    repeat (2) @(negedge clock);
    chk("int_a_done_rst", 32'(if_a.clr_done), 32'h0);
    aclr_n = 1'b1;
    @(negedge clock);
    chk("int_a_done_rel", 32'(if_a.clr_done), 32'h0);
    chk("int_a_busy_rel", 32'(if_a.clr_busy), 32'h0);
    for (int i = 0; i < 16; i++) begin
      exp_a[i] = (i < 6) ? 14'h3FFF : 14'(16'h0100 + i);
      exp_c[i] = (i < 6) ? 14'h3FFF : (i < 12) ? 14'(16'h0100 + i) : 14'h0;
    end
    rd_range(16);
    chk("int_a_done_end", 32'(if_a.clr_done), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dpram_param.md
DPRAM_PARAM -- requirements
Module: dpram_param

Interface
REQ-001 Parameter DATA_W, default 14, word width in bits (1..64).
REQ-002 Parameter ADDR_W, default 18, address width in bits (1..20).
REQ-003 Parameter DEPTH, default 2**ADDR_W, number of words (2..2**ADDR_W).
REQ-004 Parameter OUT_REG, default 1: 0 gives read latency 1, 1 gives read latency 2.
REQ-005 Parameter RDW_MODE, default 0: 0 gives old data on a same-address read-during-write, 1 gives new data (bypass).
REQ-006 Parameter CLR_VALUE, default 0, DATA_W-bit word written by the clear engine.
REQ-007 clock  in  1  single clock; all logic is posedge.
REQ-008 aclr_n  in  1  reset, asynchronous assert, active-low.
REQ-009 wren  in  1  write request.
REQ-010 wraddress  in  ADDR_W  write address.
REQ-011 data  in  DATA_W  write data.
REQ-012 rden  in  1  read request.
REQ-013 rdaddress  in  ADDR_W  read address.
REQ-014 q  out  DATA_W  read data.
REQ-015 q_valid  out  1  q carries the result of a read request.
REQ-016 clr_start  in  1  start a full-memory clear.
REQ-017 clr_busy  out  1  clear in progress.
REQ-018 clr_done  out  1  one-cycle pulse on clear completion.
REQ-019 wr_drop  out  1  one-cycle pulse when a requested write is discarded.

Function
REQ-020 A user write SHALL commit data to wraddress at the posedge where wren=1, clr_busy=0 and wraddress<DEPTH.
REQ-021 A write with wren=1 while clr_busy=1, or with wraddress>=DEPTH, SHALL be discarded, and wr_drop SHALL be 1 in the following cycle.
REQ-022 A read sampled with rden=1 at edge N SHALL present q and q_valid=1 after edge N+1+OUT_REG.
REQ-023 q_valid SHALL be 0 in every cycle not matched to a read request; q SHALL hold its last value when no read completes.
REQ-024 A read with rdaddress>=DEPTH SHALL return q=0 with q_valid=1.
REQ-025 A read and a write (user or clear) to the same address at the same edge SHALL return the pre-write word when RDW_MODE=0, and the written word when RDW_MODE=1.
REQ-026 Reads SHALL remain fully functional during a clear, with unchanged latency.
REQ-027 The clear FSM SHALL have states IDLE, CLEAR and DONE.
REQ-028 IDLE→CLEAR on clr_start=1; the clear counter SHALL load 0 at that transition.
REQ-029 In CLEAR, each cycle SHALL write CLR_VALUE to the counter address and increment the counter; CLEAR→DONE after writing address DEPTH-1 (DEPTH cycles total).
REQ-030 DONE SHALL last one cycle with clr_done=1, then return to IDLE.
REQ-031 clr_busy SHALL be 1 exactly in the CLEAR state.
REQ-032 clr_start while in CLEAR or DONE SHALL be ignored, with no restart and no queuing.
REQ-033 The clear counter SHALL be sized ceil(log2(DEPTH)) bits minimum and SHALL NOT wrap past DEPTH-1.

Reset
REQ-034 On aclr_n=0, q, q_valid, clr_busy, clr_done and wr_drop SHALL be 0 immediately, the FSM SHALL be in IDLE, the counter SHALL be 0, and all in-flight reads SHALL be discarded.
REQ-035 Memory contents SHALL NOT be altered by reset; a clear interrupted by reset SHALL leave the words already cleared, SHALL leave later words unchanged, and SHALL NOT produce clr_done.
REQ-036 Reset deassertion SHALL be synchronised so that the first write or read is accepted on the second posedge after aclr_n rises.

Verification
REQ-037 Write 0x1000+i to addresses 0..9, then read 0..9 back-to-back with OUT_REG=1 -> q=0x1000+i after edge N+2, q_valid held high for 10 consecutive cycles.
REQ-038 Preload addr 5=0x1005, then write 0x2005 and read addr 5 at the same edge -> q=0x1005 with RDW_MODE=0 and 0x2005 with RDW_MODE=1; a following read returns 0x2005 in both modes.
REQ-039 ADDR_W=4, DEPTH=16, CLR_VALUE=0x3FFF, memory filled, pulse clr_start -> clr_busy high for 16 cycles, then clr_done high for 1 cycle; reads of all 16 addresses return 0x3FFF.
REQ-040 Write during clr_busy -> wr_drop pulses, and the address holds CLR_VALUE after the clear completes; clr_start mid-clear -> total clear time still 16 cycles.
REQ-041 Assert aclr_n=0 after 6 clear cycles -> outputs 0 within the same cycle, no clr_done; addresses 0..5 = CLR_VALUE and 6..15 = prior contents.
REQ-042 DEPTH=12 with ADDR_W=4; write to address 13 -> wr_drop pulses; read of address 13 -> q=0, q_valid=1; clear takes 12 cycles.
